mult_unit: RTL and testbench
============================

# mult_unit

Iterative unsigned multiplier with architectural HI/LO registers for the pipelined MIPS datapath. It is the execute-side consumer of the control unit's `mult_enable`, `sfmux_high` and `sf2reg` decode outputs. It accepts a `multu` request and computes the 2×WIDTH-bit product one bit per cycle, holding `busy` high so the hazard logic can stall. It then commits the result to HI/LO, where `mfhi`/`mflo` read it through `sf_out`.

## Interface
- `WIDTH`, 32, operand width; must be ≥ 2. HI and LO are each WIDTH bits.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `mult_enable`  in  1  start request from EX stage (decoded `multu`), qualified by pipeline valid.
- `a`  in  WIDTH  multiplicand (rs value), sampled on the accepting edge only.
- `b`  in  WIDTH  multiplier (rt value), sampled on the accepting edge only.
- `sfmux_high`  in  1  1 selects HI and 0 selects LO onto `sf_out` (mfhi/mflo).
- `busy`  out  1  multiply in progress; the pipeline stalls any `mfhi`/`mflo`/`multu` while high.
- `done`  out  1  single-cycle pulse after HI/LO commit.
- `hi`  out  WIDTH  architectural HI register.
- `lo`  out  WIDTH  architectural LO register.
- `sf_out`  out  WIDTH  `sfmux_high ? hi : lo`; purely combinational, feeds the `sf2reg` writeback mux.

## Operation
- State machine with three states:
  - IDLE, the reset state.
  - RUN.
  - DONE.
- Internal working registers:
  - `mcand`: WIDTH bits.
  - `mplier`: WIDTH bits.
  - `acc`: 2×WIDTH bits.
  - `cnt`: `$clog2(WIDTH)+1` bits.
- Accept rule:
  - When `mult_enable`=1 and state is IDLE or DONE, load `mcand`←`a`, `mplier`←`b`, `acc`←0 and `cnt`←0, and go to RUN.
  - `mult_enable` in RUN is ignored. No queueing and no restart.
- RUN step, one per edge:
  - If `mplier[0]`, add `{mcand,WIDTH'b0}`, zero-extended to 2×WIDTH+1 bits, into `acc`.
  - Then shift the (carry,`acc`) pair right by 1, shift `mplier` right by 1, and increment `cnt`.
  - The carry-out of the add is kept as the MSB shifted in, so no bit is lost.
- Completion:
  - On the RUN edge where `cnt`==WIDTH−1, the final step result is written directly into `{hi,lo}`, and the state goes to DONE.
  - The product is the full unsigned 2×WIDTH-bit result. No overflow is possible.
- DONE lasts exactly one cycle with `done`=1, then goes to IDLE unless a new start is accepted that cycle.
- HI/LO change only at commit or reset. During RUN they hold the previous result, and `sf_out` reflects them.
- `busy` = (state==RUN), registered.

## Timing
- Reset (`rst`=1 at an edge):
  - State becomes IDLE.
  - `hi`=`lo`=0, `busy`=0, `done`=0, and `acc`/`cnt` are cleared.
  - `rst` overrides a simultaneous `mult_enable`.
- Let E0 be the accepting edge.
  - `busy`=1 from after E0 through the cycle before E0+WIDTH.
  - HI/LO are updated at edge E0+WIDTH.
  - `done`=1 and `busy`=0 in the cycle after E0+WIDTH.
  - Latency is WIDTH cycles from accept to readable result (32 for the default WIDTH).
- Back-to-back: a start in the DONE cycle is accepted.
  - `done` is still 1 in that cycle.
  - `busy` rises on the next cycle.
  - The new result commits WIDTH cycles later.
- Reset mid-RUN aborts the operation. HI/LO clear to 0, not the old value, and no `done` pulse is produced.
- Operands are not re-sampled during RUN. Changes on `a`/`b` after E0 have no effect.
- `sf_out` has zero-cycle latency from `sfmux_high`, `hi` and `lo`.

## Test plan
- Basic multiply:
  - Stimulus: reset, then `a`=3, `b`=5, `mult_enable` pulsed for 1 cycle.
  - Response: `busy` high for exactly 32 cycles; then `hi`=0, `lo`=15 and `done` pulses once; `sf_out`=15 with `sfmux_high`=0 and 0 with `sfmux_high`=1.
- Carry corner:
  - Stimulus: `a`=`b`=0xFFFFFFFF.
  - Response: `hi`=0xFFFFFFFE, `lo`=0x00000001.
- Mid-run start ignored:
  - Stimulus: `a`=0x00010000, `b`=0x00010000; during RUN, pulse `mult_enable` with `a`=7, `b`=7.
  - Response: `hi`=0x00000001, `lo`=0; exactly one `done` pulse; `busy` never extends past 32 cycles.
- Stale value held during RUN:
  - Stimulus: first result `hi`=0, `lo`=15; start 0x80000000×2.
  - Response: `lo` reads 15 throughout RUN; after commit, `hi`=1 and `lo`=0.
- Back-to-back:
  - Stimulus: assert `mult_enable` in the DONE cycle with 6×7.
  - Response: `done` and accept occur in the same cycle; after 32 more cycles, `lo`=42 and `hi`=0.
- Reset mid-run:
  - Stimulus: `rst`=1 at RUN cycle 10 after a prior result of `lo`=15.
  - Response: `busy`=0, `hi`=`lo`=0 next cycle; no `done` pulse; a following 2×9 yields `lo`=18.

Source files
------------

// File: rtl/mult_unit_if.sv
// mult_unit_if: EX-stage to multiplier bundle.
//   master (pipeline): drives mult_enable, a, b, sfmux_high;
//                      observes busy, done, hi, lo, sf_out.
//   slave  (mult_unit): the reverse directions.
interface mult_unit_if #(
  parameter int WIDTH = 32
);
  logic             mult_enable;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sfmux_high;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] sf_out;

  modport master (
    output mult_enable, a, b, sfmux_high,
    input  busy, done, hi, lo, sf_out
  );

  modport slave (
    input  mult_enable, a, b, sfmux_high,
    output busy, done, hi, lo, sf_out
  );
endinterface

// File: rtl/mult_unit.sv
// mult_unit: iterative unsigned shift-add multiplier with architectural
// HI/LO registers (multu / mfhi / mflo).
//   clk         : rising-edge clock
//   rst         : synchronous active-high reset
//   bus         : mult_unit_if.slave (start request, operands, HI/LO select,
//                 busy/done status, HI/LO and the sf_out read mux)
//   dbg_state_o : current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: mult_enable is a start request with ready = !busy. It is
// accepted on any edge where the unit is IDLE or DONE; a and b are sampled
// only on that edge. While busy is high, requests are dropped (no queueing,
// no restart), so the pipeline must stall. done pulses for one cycle after
// HI/LO commit.
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  mult_unit_if.slave       bus,
  output logic [1:0]       dbg_state_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q;

  logic               accept;
  logic               last_step;
  logic [2*WIDTH:0]   sum;
  logic [2*WIDTH-1:0] step;

  assign accept    = bus.mult_enable && (state_q != RUN);
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  // One shift-add step. The sum is one bit wider than acc so the carry-out
  // of the add becomes the MSB after the right shift.
  always_comb begin
    sum  = {1'b0, acc_q};
    if (mplier_q[0]) begin
      sum = {1'b0, acc_q} + {1'b0, mcand_q, {WIDTH{1'b0}}};
    end
    step = sum[2*WIDTH:1];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
      if (accept) begin
        mcand_q  <= bus.a;
        mplier_q <= bus.b;
        acc_q    <= '0;
        cnt_q    <= '0;
      end else if (state_q == RUN) begin
        acc_q    <= step;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CNT_W'(1);
        // Final step goes straight into HI/LO so the result is readable
        // WIDTH cycles after the accepting edge.
        if (last_step) begin
          {hi_q, lo_q} <= step;
        end
      end
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.sf_out  = bus.sfmux_high ? hi_q : lo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mult_unit.sv
module tb_mult_unit;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  mult_unit_if #(.WIDTH(W)) bus ();

  mult_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] model_hilo;  // last committed {HI,LO}
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs,
                          input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; drives a request that the next posedge accepts,
  // follows the run, and returns at the negedge of the DONE cycle.
  task automatic do_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                       input bit mid_start);
    int bad_busy = 0;
    int bad_done = 0;
    int bad_hold = 0;
    logic [2*W-1:0] prev;
    logic [2*W-1:0] exp_v;
    exp_q.push_back(64'(op_a) * 64'(op_b));
    prev = model_hilo;
    bus.a = op_a;
    bus.b = op_b;
    bus.mult_enable = 1'b1;
    bus.sfmux_high = 1'b0;
    @(negedge clk);
    bus.mult_enable = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    for (int i = 0; i < W; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.busy !== 1'b1) bad_busy++;
      if (bus.done !== 1'b0) bad_done++;
      if ({bus.hi, bus.lo} !== prev || bus.sf_out !== prev[W-1:0]) bad_hold++;
      if (mid_start && i == 5) begin
        bus.mult_enable = 1'b1;
        bus.a = 7;
        bus.b = 7;
      end
      if (mid_start && i == 6) bus.mult_enable = 1'b0;
    end
    @(negedge clk);
    exp_v = exp_q.pop_front();
    model_hilo = exp_v;
    check_eq("busy_during_run", 64'(bad_busy), 64'd0);
    check_eq("no_done_during_run", 64'(bad_done), 64'd0);
    check_eq("hilo_held_during_run", 64'(bad_hold), 64'd0);
    check_eq("busy_after_commit", 64'(bus.busy), 64'd0);
    check_eq("done_pulse", 64'(bus.done), 64'd1);
    check_eq("dbg_state_done", 64'(dbg_state), 64'd2);
    check_eq("hi", 64'(bus.hi), 64'(exp_v[2*W-1:W]));
    check_eq("lo", 64'(bus.lo), 64'(exp_v[W-1:0]));
    check_eq("sf_out_lo", 64'(bus.sf_out), 64'(exp_v[W-1:0]));
    bus.sfmux_high = 1'b1;
    #1;
    check_eq("sf_out_hi", 64'(bus.sf_out), 64'(exp_v[2*W-1:W]));
    bus.sfmux_high = 1'b0;
    #1;
  endtask

  task automatic check_done_dropped();
    @(negedge clk);
    check_eq("done_single_cycle", 64'(bus.done), 64'd0);
    check_eq("idle_after_done", 64'(bus.busy), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bad;
    logic [W-1:0] ra, rb;
    bus.mult_enable = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.sfmux_high = 1'b0;
    model_hilo = '0;

    // Reset, with a start request present that reset must override.
    rst = 1'b1;
    bus.mult_enable = 1'b1;
    bus.a = 5;
    bus.b = 5;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    check_eq("rst_hi", 64'(bus.hi), 64'd0);
    check_eq("rst_lo", 64'(bus.lo), 64'd0);
    check_eq("rst_state", 64'(dbg_state), 64'd0);
    bus.mult_enable = 1'b0;
    rst = 1'b0;

    // Basic multiply 3 x 5.
    @(negedge clk);
    do_op(32'd3, 32'd5, 1'b0);
    check_done_dropped();

    // Stale value held: LO reads 15 during the whole run.
    @(negedge clk);
    do_op(32'h8000_0000, 32'd2, 1'b0);
    check_done_dropped();

    // Carry corner.
    @(negedge clk);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check_done_dropped();

    // Start during RUN is ignored.
    @(negedge clk);
    do_op(32'h0001_0000, 32'h0001_0000, 1'b1);
    check_done_dropped();

    // Back-to-back: second start issued in the DONE cycle.
    @(negedge clk);
    do_op(32'd4, 32'd4, 1'b0);
    do_op(32'd6, 32'd7, 1'b0);
    check_done_dropped();

    // Reset at RUN cycle 10 after a prior result of 15.
    @(negedge clk);
    do_op(32'd3, 32'd5, 1'b0);
    @(negedge clk);
    bus.a = 32'h1234_5678;
    bus.b = 32'h9ABC_DEF0;
    bus.mult_enable = 1'b1;
    @(negedge clk);
    bus.mult_enable = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_hilo = '0;
    check_eq("abort_busy", 64'(bus.busy), 64'd0);
    check_eq("abort_hi", 64'(bus.hi), 64'd0);
    check_eq("abort_lo", 64'(bus.lo), 64'd0);
    check_eq("abort_state", 64'(dbg_state), 64'd0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
      @(negedge clk);
    end
    check_eq("abort_no_done", 64'(bad), 64'd0);
    do_op(32'd2, 32'd9, 1'b0);
    check_done_dropped();

    // Randomized operations, some issued back-to-back.
    for (int n = 0; n < 10; n++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 4) == 0) ra = '0;
      if ($urandom_range(0, 4) == 0) rb = {W{1'b1}};
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      do_op(ra, rb, bit'($urandom_range(0, 1)));
    end
    check_done_dropped();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
